// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch unit with a small prefetch queue.
//
// Keeps one fetch PC and issues one sequential request per cycle while the
// queue plus the requests still in flight leave room for another entry. The
// memory answers in request order. Each kept answer is written to the queue
// tail together with its address, which is taken from an address FIFO that is
// filled at request time. A redirect empties the queue and the address FIFO
// and reloads the PC. Every answer already in flight is marked stale and is
// then dropped as it arrives.
//
// Ports
//   i_clk, i_rstb          clock; asynchronous active-low reset
//   i_clk_en               global enable (no state change and no request when low)
//   i_jump, i_jump_addr    redirect request and target
//   o_ireq, o_iaddr        fetch request and address to instruction memory
//   i_ivalid, i_instr      in-order memory response
//   o_valid, o_instr, o_pc queue head (instruction and its address)
//   i_ready                decode takes the head
module ifetch_queue #(
  parameter int             IW       = 24,
  parameter int             AW       = 24,
  parameter int             DEPTH    = 4,
  parameter logic [AW-1:0]  RST_ADDR = '0
) (
  input  logic          i_clk,
  input  logic          i_rstb,
  input  logic          i_clk_en,
  input  logic          i_jump,
  input  logic [AW-1:0] i_jump_addr,
  output logic          o_ireq,
  output logic [AW-1:0] o_iaddr,
  input  logic          i_ivalid,
  input  logic [IW-1:0] i_instr,
  output logic          o_valid,
  output logic [IW-1:0] o_instr,
  output logic [AW-1:0] o_pc,
  input  logic          i_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] af_wr_q, af_wr_d;
  logic [PW-1:0] af_rd_q, af_rd_d;

  logic [IW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];
  logic [AW-1:0] af_mem    [DEPTH];

  logic [CW:0] inflight;
  logic        req, rsp, keep, pop;

  // Room check counts the queue entries plus every request still in flight.
  // Stale requests count too, so a redirect never lets the total exceed DEPTH.
  assign inflight = {1'b0, occ_q} + {1'b0, out_q};
  assign req      = i_rstb & i_clk_en & ~i_jump & (inflight < (CW+1)'(DEPTH));
  assign rsp      = i_clk_en & i_ivalid;
  assign keep     = rsp & (disc_q == '0) & ~i_jump;
  assign pop      = i_clk_en & o_valid & i_ready & ~i_jump;

  assign o_ireq  = req;
  assign o_iaddr = pc_q;
  assign o_valid = (occ_q != '0);
  // Head storage itself has no reset. Its outputs are forced to zero while
  // the queue is empty, so reset is visible on them at once.
  assign o_instr = o_valid ? instr_mem[head_q] : '0;
  assign o_pc    = o_valid ? pc_mem[head_q]    : '0;

  always_comb begin
    pc_d    = pc_q;
    occ_d   = occ_q;
    out_d   = out_q;
    disc_d  = disc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    af_wr_d = af_wr_q;
    af_rd_d = af_rd_q;
    if (i_clk_en) begin
      if (i_jump) begin
        // Every request still in flight is now stale. That includes any
        // discard already pending, and an answer arriving in this same cycle
        // is dropped here.
        pc_d    = i_jump_addr;
        occ_d   = '0;
        head_d  = '0;
        tail_d  = '0;
        af_wr_d = '0;
        af_rd_d = '0;
        out_d   = out_q - CW'(rsp);
        disc_d  = out_q - CW'(rsp);
      end else begin
        if (req) begin
          pc_d    = pc_q + AW'(1);
          af_wr_d = af_wr_q + PW'(1);
        end
        if (rsp && (disc_q != '0)) begin
          disc_d = disc_q - CW'(1);
        end
        if (keep) begin
          tail_d  = tail_q + PW'(1);
          af_rd_d = af_rd_q + PW'(1);
        end
        if (pop) begin
          head_d = head_q + PW'(1);
        end
        out_d = out_q + CW'(req) - CW'(rsp);
        occ_d = occ_q + CW'(keep) - CW'(pop);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      pc_q    <= RST_ADDR;
      occ_q   <= '0;
      out_q   <= '0;
      disc_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      af_wr_q <= '0;
      af_rd_q <= '0;
    end else begin
      pc_q    <= pc_d;
      occ_q   <= occ_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      af_wr_q <= af_wr_d;
      af_rd_q <= af_rd_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (req) begin
      af_mem[af_wr_q] <= pc_q;
    end
    if (keep) begin
      instr_mem[tail_q] <= i_instr;
      pc_mem[tail_q]    <= af_mem[af_rd_q];
    end
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter IW, default 24, instruction width in bits.
REQ-002 Parameter AW, default 24, instruction address width in bits.
REQ-003 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-004 Parameter RST_ADDR, default 0, first fetch address after reset.
REQ-005 i_clk  in  1  clock; all state on rising edge.
REQ-006 i_rstb  in  1  reset, asynchronous, active-low.
REQ-007 i_clk_en  in  1  global enable; when low, no state changes and o_ireq SHALL be 0.
REQ-008 i_jump  in  1  redirect request from execute (taken branch/jump/call).
REQ-009 i_jump_addr  in  AW  redirect target.
REQ-010 o_ireq  out  1  fetch request to instruction memory, one address per cycle.
REQ-011 o_iaddr  out  AW  fetch address, valid when o_ireq=1.
REQ-012 i_ivalid  in  1  instruction memory response strobe; responses return in request order.
REQ-013 i_instr  in  IW  response data, valid with i_ivalid.
REQ-014 o_valid  out  1  queue head holds a valid instruction.
REQ-015 o_instr  out  IW  head instruction.
REQ-016 o_pc  out  AW  address of head instruction.
REQ-017 i_ready  in  1  decode consumes head when o_valid & i_ready & i_clk_en.

Function
REQ-018 Fetch PC register SHALL hold the next address to request; on an accepted request (o_ireq & i_clk_en) it SHALL increment by 1, wrapping modulo 2^AW.
REQ-019 o_ireq SHALL be 1 iff i_clk_en=1, i_jump=0, and (queue occupancy + outstanding requests) < DEPTH.
REQ-020 Outstanding counter SHALL increment on accepted request, decrement on i_ivalid, and be unchanged when both occur in the same cycle.
REQ-021 A non-discarded response SHALL be written to the tail with its address (taken from an internal address FIFO of DEPTH entries written on request), latency 1 cycle to o_valid.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged; pop from empty and push to full SHALL never occur by construction (REQ-019).
REQ-023 o_instr/o_pc SHALL come directly from head storage (no extra register stage); o_valid=0 when empty.
REQ-024 On i_jump=1 with i_clk_en=1: queue and address FIFO SHALL empty, fetch PC SHALL load i_jump_addr, discard counter SHALL load the outstanding count (minus 1 if i_ivalid in that cycle), o_ireq=0 that cycle.
REQ-025 While discard counter is non-zero, each i_ivalid SHALL decrement it and the response SHALL be dropped.
REQ-026 First request to i_jump_addr SHALL issue the cycle after i_jump; o_valid for the target SHALL assert no earlier than one cycle after its response.
REQ-027 i_jump takes priority over a same-cycle pop and push; consumption in that cycle SHALL not occur.
REQ-028 Back-to-back i_jump SHALL each apply; the latest target wins.
REQ-029 Occupancy, outstanding and discard counters SHALL be clog2(DEPTH)+1 bits; none SHALL overflow or underflow.

Reset
REQ-030 While i_rstb=0: fetch PC=RST_ADDR, all counters 0, queue empty, o_valid=0, o_ireq=0, o_instr=0, o_pc=0.
REQ-031 First o_ireq with o_iaddr=RST_ADDR SHALL occur on the first enabled edge after i_rstb rises.
REQ-032 Reset mid-operation SHALL drop all queued, outstanding and discard state; later stale responses before the first new request are not permitted (bench duty).

Verification
REQ-033 Streaming: 1-cycle memory, i_ready=1 -> o_iaddr 0,1,2..., o_valid continuous from cycle 2, o_pc increments by 1 with matching o_instr.
REQ-034 Backpressure: i_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests outstanding/held, o_ireq=0 until pop, no data loss.
REQ-035 Flush: 3-cycle memory, i_jump to 0x100 with 3 outstanding -> 3 stale responses dropped, next o_valid shows o_pc=0x100.
REQ-036 Wrap: AW=8, RST_ADDR=0xFE -> o_iaddr 0xFE,0xFF,0x00.
REQ-037 i_clk_en=0 for 5 cycles mid-stream -> no counter, PC or queue change, o_ireq=0.
REQ-038 Async reset asserted mid-stream -> outputs immediately reach REQ-030 values; restart at RST_ADDR.
